// File: rtl/axi4_tg_pkg.sv
// axi4_tg_pkg: shared constants and types for the AXI4 write traffic master.
// Imported by axi4_traffic_master and axi4_tg_wbeat_gen.
package axi4_tg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } tg_state_e;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axi4_tg_wbeat_gen.sv
// axi4_tg_wbeat_gen: W-channel beat/last counter and counting data pattern.
// A burst is only offered once its AW has been accepted (bursts_q < aw_cnt_i).
module axi4_tg_wbeat_gen
  import axi4_tg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [15:0]       aw_cnt_i,
  input  logic [7:0]        len_i,
  input  logic              wready_i,
  output logic              wvalid_o,
  output logic              wlast_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic [15:0] bursts_q;
  logic [7:0]  beat_q;
  logic [31:0] idx_q;
  logic        last;
  logic        w_hs;

  assign last     = (beat_q == len_i);
  assign wvalid_o = en_i && (bursts_q < aw_cnt_i);
  assign wlast_o  = wvalid_o && last;
  assign wdata_o  = DATA_W'(idx_q);
  assign w_hs     = wvalid_o && wready_i;

  // Advance beat, burst and pattern counters on each W handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bursts_q <= '0;
      beat_q   <= '0;
      idx_q    <= '0;
    end else if (clear_i) begin
      bursts_q <= '0;
      beat_q   <= '0;
      idx_q    <= '0;
    end else if (w_hs) begin
      idx_q <= idx_q + 32'd1;
      if (last) begin
        beat_q   <= '0;
        bursts_q <= bursts_q + 16'd1;
      end else begin
        beat_q <= beat_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/axi4_traffic_master.sv
// axi4_traffic_master: AXI4 write-burst traffic generator with B error count.
// Option AXI4_TRAFFIC_MASTER_BID_CHECK_EN: count B responses with wrong BID.
module axi4_traffic_master
  import axi4_tg_pkg::*;
#(
  parameter int AXI_ID_WIDTH     = 4,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int OUTSTANDING_WREQ = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        start,
  input  logic [AXI_ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [7:0]                  cfg_len,
  input  logic [15:0]                 cfg_num,
  input  logic [AXI_ID_WIDTH-1:0]     cfg_id,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 err_count,
  output logic [AXI_ID_WIDTH-1:0]     axi_m_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_m_awaddr,
  output logic [7:0]                  axi_m_awlen,
  output logic [2:0]                  axi_m_awsize,
  output logic [1:0]                  axi_m_awburst,
  output logic                        axi_m_awvalid,
  input  logic                        axi_m_awready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_m_wstrb,
  output logic                        axi_m_wlast,
  output logic                        axi_m_wvalid,
  input  logic                        axi_m_wready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_m_bid,
  input  logic [1:0]                  axi_m_bresp,
  input  logic                        axi_m_bvalid,
  output logic                        axi_m_bready
);

  localparam int AW_SIZE = $clog2(AXI_DATA_WIDTH / 8);

  tg_state_e                 state_q;
  logic [7:0]                len_q;
  logic [15:0]               num_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic                      awvalid_q;
  logic [15:0]               aw_cnt_q;
  logic [15:0]               b_cnt_q;
  logic [15:0]               err_q;
  logic                      busy_q;
  logic                      done_q;

  logic                      run;
  logic                      accept;
  logic                      aw_hs;
  logic                      b_hs;
  logic [15:0]               aw_cnt_d;
  logic [15:0]               b_cnt_d;
  logic [15:0]               outst_d;
  logic                      aw_more;
  logic                      bid_bad;
  logic                      b_err;
  logic [15:0]               err_d;
  logic [AXI_ADDR_WIDTH-1:0] stride;

  assign run      = (state_q == S_RUN);
  assign accept   = (state_q == S_IDLE) && start;
  assign aw_hs    = awvalid_q && axi_m_awready;
  assign b_hs     = run && axi_m_bvalid;
  assign aw_cnt_d = aw_cnt_q + 16'(aw_hs);
  assign b_cnt_d  = b_cnt_q + 16'(b_hs);
  assign outst_d  = aw_cnt_d - b_cnt_d;
  assign aw_more  = (aw_cnt_d < num_q) &&
                    (outst_d < 16'(OUTSTANDING_WREQ));
  assign stride   = AXI_ADDR_WIDTH'({1'b0, len_q} + 9'd1) << AW_SIZE;

`ifdef AXI4_TRAFFIC_MASTER_BID_CHECK_EN
  assign bid_bad = (axi_m_bid != id_q);
`else
  logic unused_ok;
  assign unused_ok = ^axi_m_bid;
  assign bid_bad   = 1'b0;
`endif

  // One error per response, whichever fault it carries.
  assign b_err = ((axi_m_bresp & RESP_SLVERR) != RESP_OKAY) || bid_bad;
  assign err_d = (b_hs && b_err) ? sat_inc16(err_q) : err_q;

  // Control FSM with AW issue, B accounting and registered status outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      num_q     <= '0;
      id_q      <= '0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      aw_cnt_q  <= '0;
      b_cnt_q   <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            len_q     <= cfg_len;
            num_q     <= cfg_num;
            id_q      <= cfg_id;
            awaddr_q  <= cfg_addr;
            awvalid_q <= (cfg_num != 16'd0);
            aw_cnt_q  <= '0;
            b_cnt_q   <= '0;
            err_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          aw_cnt_q <= aw_cnt_d;
          b_cnt_q  <= b_cnt_d;
          err_q    <= err_d;
          if (aw_hs) begin
            awaddr_q <= awaddr_q + stride;
          end
          awvalid_q <= (awvalid_q && !axi_m_awready) || aw_more;
          if (b_cnt_q == num_q) begin
            awvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  axi4_tg_wbeat_gen #(
    .DATA_W   (AXI_DATA_WIDTH)
  ) u_wbeat (
    .clk_i    (aclk),
    .rst_ni   (aresetn),
    .clear_i  (accept),
    .en_i     (run),
    .aw_cnt_i (aw_cnt_q),
    .len_i    (len_q),
    .wready_i (axi_m_wready),
    .wvalid_o (axi_m_wvalid),
    .wlast_o  (axi_m_wlast),
    .wdata_o  (axi_m_wdata)
  );

  assign axi_m_awid    = id_q;
  assign axi_m_awaddr  = awaddr_q;
  assign axi_m_awlen   = len_q;
  assign axi_m_awsize  = 3'(AW_SIZE);
  assign axi_m_awburst = BURST_INCR;
  assign axi_m_awvalid = awvalid_q;
  assign axi_m_wstrb   = '1;
  assign axi_m_bready  = run;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_axi4_traffic_master.sv
// tb_axi4_traffic_master: table-driven runs against a reactive slave model.
// Build with AXI4_TRAFFIC_MASTER_BID_CHECK_EN to exercise the BID check.
module tb_axi4_traffic_master;

  localparam int OUTS = 2;

`ifdef AXI4_TRAFFIC_MASTER_BID_CHECK_EN
  localparam logic [15:0] BIDERR3 = 16'd3;
`else
  localparam logic [15:0] BIDERR3 = 16'd0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [15:0] num;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        bidx;
    int          aw_hold;
    int          b_delay;
    logic        wthr;
    logic [15:0] exp_err;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [31:0] cfg_addr;
  logic [7:0]  cfg_len;
  logic [15:0] cfg_num;
  logic [3:0]  cfg_id;
  logic        busy, done;
  logic [15:0] err_count;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[7];
  vec_t cur;
  int   aw_cnt, w_beats, b_cnt, done_cnt, run_cyc;
  int   bq[$];
  bit   mon_en;
  bit   p_aw, p_w, p_wlast;
  logic [31:0] p_awaddr, p_wdata;

  always #5 aclk = ~aclk;

  axi4_traffic_master #(
    .AXI_ID_WIDTH     (4),
    .AXI_ADDR_WIDTH   (32),
    .AXI_DATA_WIDTH   (32),
    .OUTSTANDING_WREQ (OUTS)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .cfg_addr      (cfg_addr),
    .cfg_len       (cfg_len),
    .cfg_num       (cfg_num),
    .cfg_id        (cfg_id),
    .busy          (busy),
    .done          (done),
    .err_count     (err_count),
    .axi_m_awid    (awid),
    .axi_m_awaddr  (awaddr),
    .axi_m_awlen   (awlen),
    .axi_m_awsize  (awsize),
    .axi_m_awburst (awburst),
    .axi_m_awvalid (awvalid),
    .axi_m_awready (awready),
    .axi_m_wdata   (wdata),
    .axi_m_wstrb   (wstrb),
    .axi_m_wlast   (wlast),
    .axi_m_wvalid  (wvalid),
    .axi_m_wready  (wready),
    .axi_m_bid     (bid),
    .axi_m_bresp   (bresp),
    .axi_m_bvalid  (bvalid),
    .axi_m_bready  (bready)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model and protocol monitor; decides readies at each negedge.
  initial forever begin
    logic [31:0] ea;
    logic        el;
    @(negedge aclk);
    run_cyc++;
    if (!aresetn) begin
      bq.delete();
      bvalid  = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      p_aw    = 1'b0;
      p_w     = 1'b0;
    end else begin
      awready = (run_cyc >= cur.aw_hold);
      wready  = cur.wthr ? (run_cyc % 2 == 1) : 1'b1;
      bvalid  = (bq.size() > 0) && (bq[0] <= run_cyc);
      bid     = cur.id ^ {3'b000, cur.bidx};
      bresp   = cur.resp;
      if (done) done_cnt++;
      if (mon_en) begin
        if (p_aw)
          chk("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
        if (p_w)
          chk("w_stable", {wvalid, wlast, wdata},
              {1'b1, p_wlast, p_wdata});
        if (bvalid && bready) begin
          void'(bq.pop_front());
          b_cnt++;
        end
        if (wvalid && wready) begin
          el = (w_beats % (int'(cur.len) + 1)) == int'(cur.len);
          chk("w_after_aw",
              (w_beats / (int'(cur.len) + 1)) < aw_cnt, 1'b1);
          chk("w_beat", {wdata, wlast, wstrb},
              {32'(w_beats), el, 4'hF});
          if (el) bq.push_back(run_cyc + 1 + cur.b_delay);
          w_beats++;
        end
        if (awvalid && awready) begin
          ea = cur.addr + 32'(aw_cnt) * ((32'(cur.len) + 1) << 2);
          chk("aw_beat", {awaddr, awlen, awid, awsize, awburst},
              {ea, cur.len, cur.id, 3'd2, 2'b01});
          aw_cnt++;
          chk("outstanding", (aw_cnt - b_cnt) <= OUTS, 1'b1);
        end
      end
      p_aw     = awvalid && !awready;
      p_awaddr = awaddr;
      p_w      = wvalid && !wready;
      p_wlast  = wlast;
      p_wdata  = wdata;
    end
  end

  task automatic mon_reset(input vec_t v);
    cur      = v;
    aw_cnt   = 0;
    w_beats  = 0;
    b_cnt    = 0;
    done_cnt = 0;
    run_cyc  = 0;
    bq.delete();
    p_aw     = 1'b0;
    p_w      = 1'b0;
    mon_en   = 1'b1;
  endtask

  task automatic pulse_start(input vec_t v);
    @(negedge aclk); #2;
    cfg_addr = v.addr;
    cfg_len  = v.len;
    cfg_num  = v.num;
    cfg_id   = v.id;
    start    = 1'b1;
    @(negedge aclk); #2;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit poke);
    bit seen;
    mon_reset(v);
    pulse_start(v);
    chk("busy_after_start", busy, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge aclk); #2;
      start = poke && (i == 3);
      if (poke && i == 3) begin
        cfg_addr = 32'hDEAD_0000;
        cfg_len  = 8'd0;
        cfg_num  = 16'd9;
      end
      seen = (done_cnt != 0);
    end
    start = 1'b0;
    chk("done_seen", seen, 1'b1);
    repeat (3) begin
      @(negedge aclk); #2;
    end
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("busy_end", busy, 1'b0);
    chk("err_count", err_count, v.exp_err);
    chk("aw_count", 32'(aw_cnt), 32'(v.num));
    chk("w_beats", 32'(w_beats),
        32'(int'(v.num) * (int'(v.len) + 1)));
    chk("b_count", 32'(b_cnt), 32'(v.num));
  endtask

  initial begin
    vec_t z;
    // addr, len, num, id, resp, bidx, aw_hold, b_delay, wthr, exp_err
    vecs[0] = '{32'h0000_1000, 8'd3, 16'd4, 4'h2, 2'b00, 1'b0,
                0, 0, 1'b0, 16'd0};
    vecs[1] = '{32'h0000_0000, 8'd0, 16'd5, 4'h5, 2'b10, 1'b0,
                0, 0, 1'b0, 16'd5};
    vecs[2] = '{32'h0000_4000, 8'd1, 16'd6, 4'h1, 2'b00, 1'b0,
                20, 50, 1'b1, 16'd0};
    vecs[3] = '{32'hFFFF_FFF0, 8'd1, 16'd3, 4'h7, 2'b11, 1'b0,
                0, 3, 1'b0, 16'd3};
    vecs[4] = '{32'h0000_0100, 8'd2, 16'd3, 4'hA, 2'b00, 1'b1,
                0, 0, 1'b0, BIDERR3};
    vecs[5] = '{32'h0000_0200, 8'd0, 16'd2, 4'h3, 2'b10, 1'b1,
                0, 0, 1'b0, 16'd2};
    vecs[6] = '{32'h0000_0300, 8'd4, 16'd2, 4'h4, 2'b01, 1'b0,
                0, 2, 1'b0, 16'd0};

    aresetn  = 1'b0;
    start    = 1'b0;
    cfg_addr = '0;
    cfg_len  = '0;
    cfg_num  = '0;
    cfg_id   = '0;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    bid      = '0;
    bresp    = '0;
    mon_en   = 1'b0;
    cur      = vecs[0];
    #3;
    chk("reset_state",
        {awvalid, wvalid, bready, busy, done, err_count, awaddr, wdata},
        '0);
    #19;
    aresetn = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], 1'b0);

    // Start pulsed while busy must not disturb the running job.
    run_vec(vecs[1], 1'b1);

    // cfg_num = 0: no traffic, done two cycles after start.
    z = vecs[0];
    z.num = 16'd0;
    mon_reset(z);
    pulse_start(z);
    chk("n0_busy", busy, 1'b1);
    chk("n0_done_early", {done, awvalid, wvalid}, 3'b000);
    @(negedge aclk); #2;
    chk("n0_done", {done, awvalid, wvalid}, 3'b100);
    @(negedge aclk); #2;
    chk("n0_after", {done, busy}, 2'b00);
    chk("n0_aw_count", 32'(aw_cnt), 32'd0);

    // Asynchronous reset in the middle of a burst.
    z = vecs[0];
    z.addr = 32'h0000_5000;
    z.len  = 8'd7;
    mon_reset(z);
    pulse_start(z);
    repeat (4) begin
      @(negedge aclk); #2;
    end
    chk("wvalid_before_reset", wvalid, 1'b1);
    mon_en  = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("async_reset", {awvalid, wvalid, bready, busy}, 4'b0000);
    repeat (2) @(negedge aclk);
    #2;
    aresetn = 1'b1;
    repeat (2) begin
      @(negedge aclk); #2;
    end
    chk("after_reset_idle",
        {awvalid, wvalid, bready, busy, done, err_count}, '0);
    run_vec(vecs[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/axi4_traffic_master.md
Name:
axi4_traffic_master

Overview:
AXI4-MM write-side traffic generator, the initiator counterpart to the team's dummy slaves and slave-side test blocks. On a start pulse it issues cfg_num INCR write bursts of cfg_len+1 beats at consecutive addresses, drives a counting data pattern, collects B responses, and reports an error count. Used in bring-up benches and for isolation testing of virtualized regions.

Parameters:
AXI_ID_WIDTH, 4, ID width; AXI_ADDR_WIDTH, 32, address width.
AXI_DATA_WIDTH, 32, data width; must be 32 or 64.
OUTSTANDING_WREQ, 8, maximum accepted AW requests without a matching B response.

Ports:
aclk  in  1  clock; all interfaces are synchronous to it
aresetn  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse; accepted only in IDLE
cfg_addr  in  AXI_ADDR_WIDTH  base address of burst 0
cfg_len  in  8  AWLEN used for every burst
cfg_num  in  16  number of bursts
cfg_id  in  AXI_ID_WIDTH  AWID used for every burst
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
err_count  out  16  B responses with bresp[1]=1, saturating
axi_m_awid  out  AXI_ID_WIDTH  latched cfg_id
axi_m_awaddr  out  AXI_ADDR_WIDTH  burst address
axi_m_awlen  out  8  latched cfg_len
axi_m_awsize  out  3  constant clog2(AXI_DATA_WIDTH/8)
axi_m_awburst  out  2  constant 2'b01 (INCR)
axi_m_awvalid  out  1  AW valid
axi_m_awready  in  1  AW ready
axi_m_wdata  out  AXI_DATA_WIDTH  beat pattern
axi_m_wstrb  out  AXI_DATA_WIDTH/8  all ones
axi_m_wlast  out  1  final beat of burst
axi_m_wvalid  out  1  W valid
axi_m_wready  in  1  W ready
axi_m_bid  in  AXI_ID_WIDTH  response ID
axi_m_bresp  in  2  response code
axi_m_bvalid  in  1  B valid
axi_m_bready  out  1  high in RUN, low otherwise

Behaviour:
- Reset (async assert, sync deassert on aclk): state IDLE. All valids, busy, done and bready are 0. err_count, all counters, awaddr and wdata are 0.
- FSM IDLE->RUN->DONE->IDLE. In IDLE, start latches cfg_*, clears err_count and enters RUN. start in any other state is ignored.
- RUN: awvalid asserts the cycle after start. Burst k address = cfg_addr + k*((cfg_len+1)<<awsize), modulo 2^AXI_ADDR_WIDTH. awvalid holds until awready.
- AW gating: issue the next AW only if aw_issued < cfg_num and (aw_issued - b_received) < OUTSTANDING_WREQ. AW+B in the same cycle leaves the outstanding count unchanged.
- W gating: W beats of burst k are driven only after AW k's handshake (no W before AW). wvalid is high while w_bursts_done < aw_issued. wlast is high on beat cfg_len.
- wdata = 32-bit run-global beat index, zero-extended or truncated to AXI_DATA_WIDTH, starting at 0. It advances on each W handshake. wdata, wlast and awaddr are stable while valid is high and ready is low.
- A B handshake increments b_received. If bresp[1]=1, err_count increments, saturating at 16'hFFFF.
- RUN->DONE when b_received == cfg_num. done pulses in DONE for one cycle, then IDLE. cfg_num=0: RUN exits on its first cycle, no AXI traffic, done 2 cycles after start.
- A B response arriving in IDLE is a protocol violation: ignored, bready=0.

Optional Feature:
AXI4_TRAFFIC_MASTER_BID_CHECK_EN.
- Defined: a B handshake with bid != latched cfg_id also increments err_count; at most one increment per response.
- Undefined: axi_m_bid is ignored.

Decomposition:
- Package axi4_tg_pkg holds resp codes (OKAY=2'b00, SLVERR=2'b10), FSM state enum and the INCR burst constant.
- One natural sub-module, axi4_tg_wbeat_gen: W-channel beat/last counter and data pattern, driven by the aw_issued count.

Test Plan:
- Always-ready OKAY slave, cfg_addr=0x1000, len=3, num=4, data 32 -> awaddr 0x1000/0x1010/0x1020/0x1030, 16 W beats with wdata 0..15, wlast on beats 3,7,11,15, err_count=0, one done pulse.
- Slave answering SLVERR on every B, num=5 -> err_count=5.
- awready low 20 cycles then high, bvalid delayed 50 cycles, OUTSTANDING_WREQ=2, num=6 -> never more than 2 AW accepted ahead of B; W never precedes its AW; wdata/awaddr stable under backpressure.
- num=0 -> no valids asserted, done pulses 2 cycles after start; start pulsed while busy -> no effect.
- aresetn asserted mid-burst -> all valids 0 asynchronously, IDLE after release, a subsequent run from start is correct.
- With BID_CHECK_EN, slave returns bid=cfg_id^1 with OKAY on 3 bursts -> err_count=3.
